core_sequencer: RTL and testbench
=================================

# core_sequencer

Multi-cycle control unit for the core: sequences each instruction through fetch, decode, execute, optional memory access and writeback around the existing instruction decoder, ALU and register file. Owns the program counter and the instruction register. Drives the instruction- and data-memory request handshakes, and produces per-stage enables and the register-file write strobe. Sits between the memory interfaces and the decode/execute datapath.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: single core clock; all state updates on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `imem_addr` out 32: fetch address, equal to `pc`.
- `imem_req` out 1: fetch request, held high until accepted.
- `imem_ready` in 1: fetch accepted, with `imem_rdata` valid in that cycle.
- `imem_rdata` in 32: fetched instruction word.
- `instr_raw` out 32: instruction register, fed to the decoder.
- `dec_illegal` in 1: decoder matched no known instruction.
- `dec_is_mem` in 1: instruction is a load or store.
- `dec_is_ctrl` in 1: instruction is a branch or jal.
- `dec_writes_rd` in 1: instruction writes rd.
- `ctrl_taken` in 1: ALU branch condition met. Treated as 1 for jal by the datapath.
- `ctrl_target` in 32: branch or jump target, computed by the datapath.
- `dmem_req` out 1: data access request, held high until accepted.
- `dmem_ready` in 1: data access complete.
- `exec_en` out 1: ALU operand/result register capture strobe.
- `reg_we` out 1: register-file write strobe, 1 cycle.
- `pc` out 32: current instruction address.
- `halted` out 1: core stopped on an illegal instruction or a misaligned target.
- `instret` out 32: retired-instruction counter.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset values: state=FETCH, `pc`=RESET_PC, `instr_raw`=0, `instret`=0, `halted`=0, all strobes and requests 0.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_ready`=1: `instr_raw` <= `imem_rdata`, go to DECODE.
  - Otherwise stay in FETCH with `imem_req` still high.
- DECODE: decoder outputs are sampled.
  - `dec_illegal`=1 → HALT.
  - Otherwise → EXEC.
- EXEC:
  - `exec_en`=1 for exactly this cycle.
  - `dec_is_mem`=1 → MEM, else → WB.
- MEM:
  - `dmem_req`=1 until `dmem_ready`=1, then → WB.
  - `dmem_ready` arriving in the same cycle `dmem_req` first rises is legal: 1-cycle MEM.
- WB:
  - `reg_we` = `dec_writes_rd` for this cycle only.
  - `instret` += 1, wrapping at 2^32.
  - Next PC: if `dec_is_ctrl`=1 and `ctrl_taken`=1, next PC = `ctrl_target`; otherwise next PC = `pc`+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - If the selected target has [1:0]≠0 → HALT; `pc` keeps the branch address and no retire occurs. `reg_we` and `instret` are suppressed in that case.
  - Otherwise `pc` <= next PC and → FETCH.
- HALT:
  - `halted`=1 and all requests/strobes 0.
  - Only `rstn` leaves this state.
- Illegal instruction: no `exec_en`, no `reg_we`, no `instret` increment; `pc` stays at the illegal instruction.
- `imem_ready`/`dmem_ready` outside their request states are ignored.

## Timing
- Non-memory instruction: FETCH + DECODE + EXEC + WB.
  - 4 cycles with zero-wait fetch, i.e. `imem_ready` in the first FETCH cycle.
  - Each fetch wait cycle adds 1 cycle.
- Memory instruction: 5 cycles minimum, plus 1 per `dmem_ready` wait cycle.
- `imem_addr` is stable for the whole time `imem_req` is high. Requests are never withdrawn before acceptance except by reset.
- `instr_raw` changes only on the FETCH accept edge, and stays stable through DECODE..WB.
- `pc` changes only on the WB→FETCH edge.
- `reg_we`, `exec_en`: at most one high cycle per instruction, never both in the same cycle.
- Reset asserted mid-transaction (any state): outputs go to reset values immediately and asynchronously. Outstanding requests are dropped. After release, the first FETCH issues at RESET_PC.

## Test plan
- Zero-wait add stream:
  - Stimulus: RESET_PC=0, memory returns `add` words at 0,4,8 with `imem_ready` tied 1.
  - Response: `pc` goes 0→4→8 every 4 cycles; `reg_we` pulses once per instruction; `instret`=3 after 12 cycles.
- Fetch stall:
  - Stimulus: `imem_ready` held low 3 cycles.
  - Response: `imem_req` high for 4 cycles with `imem_addr` constant; the instruction retires 3 cycles later than the zero-wait case.
- Taken beq:
  - Stimulus: beq at 0x10, `ctrl_taken`=1, `ctrl_target`=0x40.
  - Response: next fetch address 0x40; `reg_we`=0. With `ctrl_taken`=0 the next address is 0x14.
- Load with 2-cycle dmem wait:
  - Response: `dmem_req` high 3 cycles, `reg_we` 1 cycle after `dmem_ready`, total latency 7 cycles.
- Illegal instruction and misaligned target:
  - Stimulus: illegal instruction at 0x8.
  - Response: `halted`=1, `pc`=0x8, `instret` unchanged, `imem_req` stays 0.
  - Stimulus: jal with target 0x42.
  - Response: HALT, `pc` stays at the jal address.
- Async reset mid-MEM:
  - Stimulus: drop `rstn` while `dmem_req`=1.
  - Response: `dmem_req`=0 in the same cycle, `pc`=RESET_PC, `instret`=0; fetch restarts after release.

Source files
------------

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: steps each instruction through
// fetch, decode, execute, optional memory access and writeback. Owns the
// program counter, the instruction register and the retired-instruction count.
module core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    // instruction memory
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    // decoder
    output logic [31:0] instr_raw,
    input  logic        dec_illegal,
    input  logic        dec_is_mem,
    input  logic        dec_is_ctrl,
    input  logic        dec_writes_rd,
    // branch unit
    input  logic        ctrl_taken,
    input  logic [31:0] ctrl_target,
    // data memory
    output logic        dmem_req,
    input  logic        dmem_ready,
    // datapath strobes and status
    output logic        exec_en,
    output logic        reg_we,
    output logic [31:0] pc,
    output logic        halted,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] next_pc;
    logic        next_pc_misaligned;

    // Writeback target: taken control transfer or sequential (wraps mod 2^32).
    always_comb begin
        next_pc            = (dec_is_ctrl && ctrl_taken) ? ctrl_target : pc_q + 32'd4;
        next_pc_misaligned = (next_pc[1:0] != 2'b00);
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        instret_d = instret_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        exec_en   = 1'b0;
        reg_we    = 1'b0;

        unique case (state_q)
            StFetch: begin
                // Gated by rstn so the request stays low while reset is held.
                imem_req = rstn;
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = dec_illegal ? StHalt : StExec;
            end
            StExec: begin
                exec_en = 1'b1;
                state_d = dec_is_mem ? StMem : StWb;
            end
            StMem: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                if (next_pc_misaligned) begin
                    // No retire: pc stays on the offending instruction.
                    state_d = StHalt;
                end else begin
                    reg_we    = dec_writes_rd;
                    instret_d = instret_q + 32'd1;
                    pc_d      = next_pc;
                    state_d   = StFetch;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StHalt;
            end
        endcase
    end

    // Architectural state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0;
            instret_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
        end
    end

    // Output mapping.
    always_comb begin
        imem_addr = pc_q;
        pc        = pc_q;
        instr_raw = instr_q;
        instret   = instret_q;
        halted    = (state_q == StHalt);
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: acts as instruction/data memory and decoder, and
// checks each instruction against a per-instruction transaction model.
module tb_core_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr_raw;
    logic        dec_illegal = 1'b0;
    logic        dec_is_mem = 1'b0;
    logic        dec_is_ctrl = 1'b0;
    logic        dec_writes_rd = 1'b0;
    logic        ctrl_taken = 1'b0;
    logic [31:0] ctrl_target = 32'h0;
    logic        dmem_req;
    logic        dmem_ready = 1'b0;
    logic        exec_en;
    logic        reg_we;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] instret;

    core_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .imem_addr    (imem_addr),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr_raw    (instr_raw),
        .dec_illegal  (dec_illegal),
        .dec_is_mem   (dec_is_mem),
        .dec_is_ctrl  (dec_is_ctrl),
        .dec_writes_rd(dec_writes_rd),
        .ctrl_taken   (ctrl_taken),
        .ctrl_target  (ctrl_target),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .exec_en      (exec_en),
        .reg_we       (reg_we),
        .pc           (pc),
        .halted       (halted),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_pc;
    logic [31:0] m_instret;
    logic        m_halted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn       = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        check("rst_imem_req", {31'h0, imem_req}, 32'h0);
        check("rst_pc", pc, RESET_PC);
        check("rst_instret", instret, 32'h0);
        check("rst_instr", instr_raw, 32'h0);
        check("rst_strobes", {28'h0, halted, dmem_req, exec_en, reg_we}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        step();
        m_pc      = RESET_PC;
        m_instret = 32'h0;
        m_halted  = 1'b0;
    endtask

    // Holds HALT for a few cycles with readies offered; nothing may move.
    task automatic check_halt_hold();
        for (int i = 0; i < 3; i++) begin
            imem_ready = 1'b1;
            dmem_ready = 1'b1;
            step();
            check("halt_state", {30'h0, halted, imem_req}, 32'h2);
            check("halt_pc", pc, m_pc);
        end
    endtask

    // One instruction from FETCH entry to the next FETCH entry (or HALT).
    task automatic run_instr(input logic [31:0] word, input logic ill, input logic mem,
                             input logic ctl, input logic wr, input logic tk,
                             input logic [31:0] tgt, input int fw, input int dw);
        int          cyc, reqc, ex, we, dreq, exp_cyc;
        bit          stable, timeout, both;
        logic [31:0] a0, npc;
        bit          mis;

        check("fetch_req", {31'h0, imem_req}, 32'h1);
        check("fetch_addr", imem_addr, m_pc);
        a0     = imem_addr;
        stable = 1'b1;
        cyc    = 0;
        reqc   = 0;
        for (int i = 0; i < fw; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            dmem_ready = 1'($urandom_range(0, 1));
            if (imem_req !== 1'b1 || imem_addr !== a0) stable = 1'b0;
            reqc += int'(imem_req);
            step();
            cyc++;
        end
        if (imem_req !== 1'b1 || imem_addr !== a0) stable = 1'b0;
        reqc += int'(imem_req);
        imem_ready    = 1'b1;
        imem_rdata    = word;
        dec_illegal   = ill;
        dec_is_mem    = mem;
        dec_is_ctrl   = ctl;
        dec_writes_rd = wr;
        ctrl_taken    = tk;
        ctrl_target   = tgt;
        step();
        cyc++;
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        check("instr_raw", instr_raw, word);

        ex = 0; we = 0; dreq = 0; both = 1'b0; timeout = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (imem_req === 1'b1 || halted === 1'b1) begin
                timeout = 1'b0;
                break;
            end
            ex += int'(exec_en);
            we += int'(reg_we);
            if (exec_en && reg_we) both = 1'b1;
            if (dmem_req) begin
                dmem_ready = (dreq == dw);
                dreq++;
            end else begin
                dmem_ready = 1'($urandom_range(0, 1));
            end
            imem_ready = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end

        // Reference: cycle count and effects from the instruction's class.
        npc = (ctl && tk) ? tgt : m_pc + 32'd4;
        mis = !ill && (npc[1:0] != 2'b00);
        if (ill) exp_cyc = fw + 2;
        else     exp_cyc = fw + 4 + (mem ? dw + 1 : 0);

        check("wait_bound", {31'h0, timeout}, 32'h0);
        check("fetch_addr_stable", {31'h0, stable}, 32'h1);
        check("fetch_req_cycles", reqc, fw + 1);
        check("instr_cycles", cyc, exp_cyc);
        check("instr_hold", instr_raw, word);
        check("exec_pulses", ex, ill ? 0 : 1);
        check("we_pulses", we, (ill || mis) ? 0 : int'(wr));
        check("dmem_req_cycles", dreq, (ill || !mem) ? 0 : dw + 1);
        check("exec_we_overlap", {31'h0, both}, 32'h0);
        if (!ill && !mis) begin
            m_pc      = npc;
            m_instret = m_instret + 32'd1;
        end
        m_halted = ill || mis;
        check("halted", {31'h0, halted}, {31'h0, m_halted});
        check("pc", pc, m_pc);
        check("instret", instret, m_instret);
        if (m_halted) begin
            check_halt_hold();
            do_reset();
        end
    endtask

    task automatic reset_mid_mem();
        bit seen;
        run_instr(32'h0000_0033, 0, 0, 0, 1, 0, 32'h0, 0, 0);
        check("pre_rst_instret", {31'h0, instret != 32'h0}, 32'h1);
        imem_ready    = 1'b1;
        imem_rdata    = 32'h0000_2003;
        dec_illegal   = 1'b0;
        dec_is_mem    = 1'b1;
        dec_is_ctrl   = 1'b0;
        dec_writes_rd = 1'b1;
        step();
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        seen       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (dmem_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("mem_req_seen", {31'h0, seen}, 32'h1);
        step();
        #2;
        rstn = 1'b0;
        #1;
        check("async_dmem_req", {31'h0, dmem_req}, 32'h0);
        check("async_pc", pc, RESET_PC);
        check("async_instret", instret, 32'h0);
        check("async_imem_req", {31'h0, imem_req}, 32'h0);
        do_reset();
        check("restart_req", {31'h0, imem_req}, 32'h1);
        check("restart_addr", imem_addr, RESET_PC);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ill, mem, ctl, wr, tk;
        logic [31:0] tgt;
        int          fw, dw;

        do_reset();
        // Zero-wait add stream 0,4,8, then a stalled add at 0xC.
        for (int i = 0; i < 3; i++) run_instr(32'h0020_81b3, 0, 0, 0, 1, 0, 32'h0, 0, 0);
        check("three_retired", instret, 32'd3);
        run_instr(32'h0020_81b3, 0, 0, 0, 1, 0, 32'h0, 3, 0);
        // beq at 0x10 taken to 0x40, then not-taken beq at 0x40.
        run_instr(32'h0220_8863, 0, 0, 1, 0, 1, 32'h40, 0, 0);
        run_instr(32'h0220_8863, 0, 0, 1, 0, 0, 32'h80, 0, 0);
        // Load with two dmem wait cycles.
        run_instr(32'h0000_a103, 0, 1, 0, 1, 0, 32'h0, 0, 2);
        // jal to the top word, then sequential wrap to 0.
        run_instr(32'h0000_006f, 0, 0, 1, 1, 1, 32'hFFFF_FFFC, 0, 0);
        run_instr(32'h0020_81b3, 0, 0, 0, 1, 0, 32'h0, 0, 0);
        check("wrap_pc", pc, 32'h0);
        // Illegal instruction at 0x8.
        run_instr(32'h0020_81b3, 0, 0, 0, 1, 0, 32'h0, 0, 0);
        run_instr(32'h0020_81b3, 0, 0, 0, 1, 0, 32'h0, 0, 0);
        run_instr(32'hFFFF_FFFF, 1, 0, 0, 1, 0, 32'h0, 1, 0);
        // jal to a misaligned target.
        run_instr(32'h0000_006f, 0, 0, 1, 1, 1, 32'h42, 0, 0);

        for (int n = 0; n < 300; n++) begin
            ill = ($urandom_range(0, 99) < 3);
            mem = ($urandom_range(0, 99) < 30);
            ctl = !mem && ($urandom_range(0, 99) < 30);
            wr  = 1'($urandom_range(0, 1));
            tk  = 1'($urandom_range(0, 1));
            tgt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            if ($urandom_range(0, 99) < 5) tgt[1:0] = 2'($urandom_range(1, 3));
            fw  = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 3);
            dw  = $urandom_range(0, 3);
            run_instr($urandom, ill, mem, ctl, wr, tk, tgt, fw, dw);
        end

        reset_mid_mem();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
